// File: rtl/month_year_pkg.sv
// Shared calendar definitions for the month/year stage.
//   bcd_t      : one packed BCD digit
//   MONTH_MIN  : lowest legal packed BCD month (01)
//   MONTH_MAX  : highest legal packed BCD month (12)
//   YEAR_MAX   : highest packed BCD year (9999), wraps to 0000
//   bcd_inc    : adds a carry-in to one BCD digit, returns {carry_out, digit}
package month_year_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0]  MONTH_MIN = 8'h01;
  localparam logic [7:0]  MONTH_MAX = 8'h12;
  localparam logic [15:0] YEAR_MAX  = 16'h9999;

  function automatic logic [4:0] bcd_inc(input bcd_t d, input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (d >= 4'd9) r = {1'b1, 4'h0};
      else           r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/month_year_bcd_year_counter.sv
// Four-digit ripple-carry BCD year counter.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, loads RESET_YEAR
//   inc      : advance the year by one (9999 wraps to 0000)
//   load     : take load_val on the next edge, overrides inc
//   load_val : packed BCD year to load, already validated by the caller
//   year     : packed BCD year {thousands, hundreds, tens, ones}
//   wrap     : combinational, high while inc would roll 9999 over to 0000
module bcd_year_counter
  import month_year_pkg::*;
#(
  parameter logic [15:0] RESET_YEAR = 16'h2015
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] year,
  output logic        wrap
);

  logic [15:0] year_q, year_d;
  logic [15:0] year_nxt;
  logic [4:0]  carry;

  // Carry ripples from the ones digit upward; carry[4] out of the thousands
  // digit means every digit was 9.
  always_comb begin
    year_nxt = year_q;
    carry    = '0;
    carry[0] = inc;
    for (int i = 0; i < 4; i++) begin
      {carry[i+1], year_nxt[i*4 +: 4]} = bcd_inc(year_q[i*4 +: 4], carry[i]);
    end
  end

  always_comb begin
    year_d = year_q;
    if (load)     year_d = load_val;
    else if (inc) year_d = year_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) year_q <= RESET_YEAR;
    else     year_q <= year_d;
  end

  assign year = year_q;
  assign wrap = carry[4];

endmodule

// File: rtl/month_year.sv
// Calendar month/year stage fed by the day counter's end-of-month carry.
//   clk_out            : system clock, rising edge
//   rst                : synchronous active-high reset
//   increase           : end-of-month pulse, advances month (and year after 12)
//   load, load_m*/y*   : parallel date load, applied only if the date is legal
//   month1/month0      : BCD month digits, also used by the day stage for limits
//   year3..year0       : BCD year digits
//   leap               : combinational Gregorian leap-year flag
//   over               : combinational, high while the year is wrapping 9999->0000
//   load_err           : high for one cycle after a rejected load
module month_year
  import month_year_pkg::*;
#(
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [15:0] RESET_YEAR  = 16'h2015
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       increase,
  input  logic       load,
  input  logic [3:0] load_m1,
  input  logic [3:0] load_m0,
  input  logic [3:0] load_y3,
  input  logic [3:0] load_y2,
  input  logic [3:0] load_y1,
  input  logic [3:0] load_y0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] year3,
  output logic [3:0] year2,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic       leap,
  output logic       over,
  output logic       load_err
);

  // True when the two-digit BCD number {t,o} is divisible by four.
  function automatic logic div4(input bcd_t t, input bcd_t o);
    logic o_even4, o_odd4;
    o_even4 = (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
    o_odd4  = (o == 4'd2) || (o == 4'd6);
    return (!t[0] && o_even4) || (t[0] && o_odd4);
  endfunction

  logic [7:0]  month_q, month_d;
  logic        load_err_q, load_err_d;
  logic [15:0] year;
  logic [15:0] load_year;
  logic [7:0]  load_month;
  logic        digits_ok, load_ok;
  logic        year_inc;
  logic        year_wrap;
  logic [4:0]  m0_inc;
  logic [7:0]  month_nxt;

  assign load_month = {load_m1, load_m0};
  assign load_year  = {load_y3, load_y2, load_y1, load_y0};

  // With every digit already known to be <=9, packed BCD compares like binary.
  assign digits_ok = (load_m1 <= 4'd9) && (load_m0 <= 4'd9) && (load_y3 <= 4'd9) &&
                     (load_y2 <= 4'd9) && (load_y1 <= 4'd9) && (load_y0 <= 4'd9);
  assign load_ok   = digits_ok && (load_month >= MONTH_MIN) && (load_month <= MONTH_MAX);

  // A load of any kind swallows a coincident increase.
  assign year_inc = increase && !load && (month_q == MONTH_MAX);

  always_comb begin
    m0_inc    = bcd_inc(month_q[3:0], 1'b1);
    month_nxt = {month_q[7:4] + {3'b000, m0_inc[4]}, m0_inc[3:0]};
    if (month_q == MONTH_MAX) month_nxt = MONTH_MIN;
  end

  always_comb begin
    month_d    = month_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) month_d    = load_month;
      else         load_err_d = 1'b1;
    end else if (increase) begin
      month_d = month_nxt;
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      month_q    <= RESET_MONTH;
      load_err_q <= 1'b0;
    end else begin
      month_q    <= month_d;
      load_err_q <= load_err_d;
    end
  end

  bcd_year_counter #(
    .RESET_YEAR(RESET_YEAR)
  ) u_year (
    .clk      (clk_out),
    .rst      (rst),
    .inc      (year_inc),
    .load     (load && load_ok),
    .load_val (load_year),
    .year     (year),
    .wrap     (year_wrap)
  );

  assign month1   = month_q[7:4];
  assign month0   = month_q[3:0];
  assign year3    = year[15:12];
  assign year2    = year[11:8];
  assign year1    = year[7:4];
  assign year0    = year[3:0];
  assign load_err = load_err_q;
  assign over     = year_wrap;

  // Century years (lower digits 00) fall back to divisibility of the upper digits.
  assign leap = (year[7:0] != 8'h00) ? div4(year[7:4], year[3:0])
                                     : div4(year[15:12], year[11:8]);

endmodule

// File: tb/tb_month_year.sv
module tb_month_year;

  logic       clk_out = 1'b0;
  logic       rst = 1'b0;
  logic       increase = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_m1 = '0, load_m0 = '0;
  logic [3:0] load_y3 = '0, load_y2 = '0, load_y1 = '0, load_y0 = '0;
  logic [3:0] month1, month0, year3, year2, year1, year0;
  logic       leap, over, load_err;

  int n_checks = 0;
  int n_pass   = 0;

  month_year dut (
    .clk_out  (clk_out),
    .rst      (rst),
    .increase (increase),
    .load     (load),
    .load_m1  (load_m1),
    .load_m0  (load_m0),
    .load_y3  (load_y3),
    .load_y2  (load_y2),
    .load_y1  (load_y1),
    .load_y0  (load_y0),
    .month1   (month1),
    .month0   (month0),
    .year3    (year3),
    .year2    (year2),
    .year1    (year1),
    .year0    (year0),
    .leap     (leap),
    .over     (over),
    .load_err (load_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_date(input string tag, input logic [7:0] m, input logic [15:0] y);
    check({tag, " month"}, {24'h0, month1, month0}, {24'h0, m});
    check({tag, " year"}, {16'h0, year3, year2, year1, year0}, {16'h0, y});
  endtask

  // Inputs are set just after a falling edge, held across one rising edge,
  // then cleared on the following falling edge where outputs are sampled.
  task automatic cycle(input logic r, input logic ld, input logic [7:0] m,
                       input logic [15:0] y, input logic inc);
    rst      = r;
    load     = ld;
    increase = inc;
    {load_m1, load_m0} = m;
    {load_y3, load_y2, load_y1, load_y0} = y;
    @(posedge clk_out);
    @(negedge clk_out);
    rst = 1'b0; load = 1'b0; increase = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [15:0] y);
    cycle(1'b0, 1'b1, m, y, 1'b0);
  endtask

  task automatic do_inc();
    cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
  endtask

  typedef struct { logic [15:0] y; logic lp; } leap_vec_t;
  leap_vec_t leap_tbl[6] = '{
    '{16'h1900, 1'b0}, '{16'h2000, 1'b1}, '{16'h2024, 1'b1},
    '{16'h2026, 1'b0}, '{16'h2100, 1'b0}, '{16'h1996, 1'b1}
  };

  initial begin
    @(negedge clk_out);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    check_date("reset", 8'h01, 16'h2015);
    check("reset leap", {31'h0, leap}, 32'h0);
    check("reset over", {31'h0, over}, 32'h0);
    check("reset load_err", {31'h0, load_err}, 32'h0);

    do_load(8'h09, 16'h2015);
    check_date("load 09/2015", 8'h09, 16'h2015);
    do_inc();
    check_date("inc 09->10", 8'h10, 16'h2015);
    do_inc();
    do_inc();
    check_date("inc back-to-back", 8'h12, 16'h2015);
    do_inc();
    check_date("inc 12/2015", 8'h01, 16'h2016);
    check("leap 2016", {31'h0, leap}, 32'h1);

    do_load(8'h12, 16'h0999);
    do_inc();
    check_date("ripple 0999", 8'h01, 16'h1000);

    do_load(8'h12, 16'h9999);
    check("over idle", {31'h0, over}, 32'h0);
    increase = 1'b1;
    #1;
    check("over during inc", {31'h0, over}, 32'h1);
    @(posedge clk_out);
    @(negedge clk_out);
    increase = 1'b0;
    check_date("wrap 9999", 8'h01, 16'h0000);
    check("leap 0000", {31'h0, leap}, 32'h1);
    check("over after wrap", {31'h0, over}, 32'h0);

    foreach (leap_tbl[i]) begin
      do_load(8'h02, leap_tbl[i].y);
      check($sformatf("leap %h", leap_tbl[i].y), {31'h0, leap}, {31'h0, leap_tbl[i].lp});
    end

    do_load(8'h05, 16'h2015);
    do_load(8'h13, 16'h2020);
    check_date("bad month 13", 8'h05, 16'h2015);
    check("load_err month 13", {31'h0, load_err}, 32'h1);
    @(negedge clk_out);
    check("load_err one cycle", {31'h0, load_err}, 32'h0);
    do_load(8'h0A, 16'h2020);
    check("load_err digit A", {31'h0, load_err}, 32'h1);
    do_load(8'h00, 16'h2020);
    check("load_err month 00", {31'h0, load_err}, 32'h1);
    do_load(8'h03, 16'h20A0);
    check_date("bad year digit", 8'h05, 16'h2015);
    check("load_err year digit", {31'h0, load_err}, 32'h1);
    cycle(1'b0, 1'b1, 8'h13, 16'h2015, 1'b1);
    check_date("bad load drops inc", 8'h05, 16'h2015);

    cycle(1'b0, 1'b1, 8'h03, 16'h2020, 1'b1);
    check_date("load+inc", 8'h03, 16'h2020);
    check("load_err good load", {31'h0, load_err}, 32'h0);

    cycle(1'b1, 1'b1, 8'h12, 16'h9999, 1'b1);
    check_date("rst beats load", 8'h01, 16'h2015);
    check("rst leap", {31'h0, leap}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
